// File: rtl/du_pkg.sv
// du_pkg: shared definitions for the MIPS debug unit.
//   - Command byte constants accepted from the UART receiver.
//   - FSM state enum and dump-section enum.
//   - Register-file size, bytes per word, and a frame-length helper.
package du_pkg;

  localparam logic [7:0] CMD_RUN  = 8'h63;  // 'c'
  localparam logic [7:0] CMD_STEP = 8'h73;  // 's'
  localparam logic [7:0] CMD_DUMP = 8'h64;  // 'd'

  localparam int REG_COUNT      = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    STEP,
    DUMP_ADDR,
    DUMP_SETTLE,
    DUMP_LATCH,
    TX_BYTE
  } du_state_e;

  // Which part of the frame the current word belongs to.
  // SEC_BODY covers registers followed by memory words.
  typedef enum logic [1:0] {
    SEC_PC,
    SEC_CNT,
    SEC_BODY
  } du_section_e;

  // Number of 32-bit words in one dump frame.
  function automatic int frame_words(input int mem_words, input bit with_count);
    return 1 + (with_count ? 1 : 0) + REG_COUNT + mem_words;
  endfunction

endpackage

// File: rtl/du_word_serializer.sv
// du_word_serializer: turns one 32-bit word into a 4-byte valid/ready
// stream, most significant byte first.
// Ports:
//   clk, reset     clock, asynchronous active-high reset
//   load           one-cycle strobe, captures load_data
//   load_data      32-bit word to send
//   tx_ready       downstream accepts the current byte
//   tx_valid       byte available on tx_data (registered)
//   tx_data        current byte, taken straight from the shift register
//   done           high in the cycle the 4th byte is accepted
module du_word_serializer
  import du_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        done
);

  logic [31:0] shift_reg;
  logic [1:0]  byte_cnt;
  logic        last_byte;

  assign last_byte = (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign done      = tx_valid & tx_ready & last_byte;

  // The top byte of the shift register is the byte on the wire; shifting
  // in zeros leaves tx_data at 0 once the word has gone out.
  assign tx_data = shift_reg[31:24];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_reg <= 32'h0;
      byte_cnt  <= 2'd0;
      tx_valid  <= 1'b0;
    end else if (load) begin
      shift_reg <= load_data;
      byte_cnt  <= 2'd0;
      tx_valid  <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      shift_reg <= {shift_reg[23:0], 8'h00};
      if (last_byte) begin
        byte_cnt <= 2'd0;
        tx_valid <= 1'b0;
      end else begin
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/mips_debug_unit.sv
// mips_debug_unit: command-driven debug controller for the pipelined MIPS core.
// Accepts 'c' (run until halt), 's' (single step) and 'd' (dump) from a UART
// receiver, gates the core clock enable, then streams a dump frame of
// PC, [cycle count], registers 0..31 and MEM_DUMP_WORDS memory words,
// each word MSB first, to a UART transmitter.
// Optional feature: define DEBUG_CYCLE_COUNT_EN to add a 32-bit count of
// enabled core cycles as the second frame word.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rx_valid, rx_data     received command byte strobe
//   tx_valid, tx_data,
//   tx_ready              byte stream to the transmitter
//   mips_ena              core clock enable
//   mips_halted, mips_pc  core halt flag and current PC
//   du_areg, du_rd_reg    register-file debug address and select
//   du_amem, du_rd_mem    data-memory debug byte address and select
//   reg_data, mem_data    debug read data from the core
//   busy                  high whenever the FSM is not in IDLE
module mips_debug_unit
  import du_pkg::*;
#(
  parameter int MEM_DUMP_WORDS = 32,
  parameter int MEM_ADDR_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        mips_ena,
  input  logic        mips_halted,
  input  logic [31:0] mips_pc,
  output logic [4:0]  du_areg,
  output logic        du_rd_reg,
  output logic [31:0] du_amem,
  output logic        du_rd_mem,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_data,
  output logic        busy
);

  localparam int BODY_WORDS = REG_COUNT + MEM_DUMP_WORDS;
  localparam int IDX_W      = $clog2(BODY_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BODY_WORDS - 1);
  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);

  du_state_e   state;
  du_section_e section;
  logic [IDX_W-1:0] word_idx;  // index into registers then memory words
  logic        load;
  logic [31:0] load_data;
  logic        word_done;
  logic [31:0] mem_offset;

  assign load       = (state == DUMP_LATCH);
  assign mem_offset = 32'(word_idx) - 32'(REG_COUNT);

`ifdef DEBUG_CYCLE_COUNT_EN
  logic [31:0] cycle_count;

  // Counts cycles the core actually ran; wraps naturally, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_count <= 32'h0;
    end else if (mips_ena) begin
      cycle_count <= cycle_count + 32'h1;
    end
  end
`endif

  // The body section reads whichever port the registered select points at.
  always_comb begin
    load_data = mips_pc;
    case (section)
      SEC_CNT: begin
`ifdef DEBUG_CYCLE_COUNT_EN
        load_data = cycle_count;
`else
        load_data = 32'h0;
`endif
      end
      SEC_BODY: load_data = du_rd_reg ? reg_data : mem_data;
      default:  load_data = mips_pc;
    endcase
  end

  du_word_serializer u_serializer (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (load_data),
    .tx_ready  (tx_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .done      (word_done)
  );

  // Debug address/select stay put through the whole word, including its
  // four bytes, and are only changed by the next DUMP_ADDR or frame end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      section   <= SEC_PC;
      word_idx  <= '0;
      mips_ena  <= 1'b0;
      busy      <= 1'b0;
      du_areg   <= 5'd0;
      du_rd_reg <= 1'b0;
      du_amem   <= 32'h0;
      du_rd_mem <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_valid) begin
            case (rx_data)
              CMD_RUN: begin
                state    <= RUN;
                busy     <= 1'b1;
                mips_ena <= ~mips_halted;
              end
              CMD_STEP: begin
                state    <= STEP;
                busy     <= 1'b1;
                mips_ena <= ~mips_halted;
              end
              CMD_DUMP: begin
                state    <= DUMP_ADDR;
                busy     <= 1'b1;
                section  <= SEC_PC;
                word_idx <= '0;
              end
              default: ;
            endcase
          end
        end

        RUN: begin
          if (mips_halted) begin
            mips_ena <= 1'b0;
            state    <= DUMP_ADDR;
          end else begin
            mips_ena <= 1'b1;
          end
        end

        STEP: begin
          mips_ena <= 1'b0;
          state    <= DUMP_ADDR;
        end

        DUMP_ADDR: begin
          du_areg   <= 5'd0;
          du_rd_reg <= 1'b0;
          du_amem   <= 32'h0;
          du_rd_mem <= 1'b0;
          if (section == SEC_BODY) begin
            if (word_idx <= REG_LAST) begin
              du_rd_reg <= 1'b1;
              du_areg   <= word_idx[4:0];
            end else begin
              du_rd_mem <= 1'b1;
              du_amem   <= mem_offset * 32'(MEM_ADDR_STEP);
            end
          end
          state <= DUMP_SETTLE;
        end

        DUMP_SETTLE: state <= DUMP_LATCH;

        DUMP_LATCH: state <= TX_BYTE;

        TX_BYTE: begin
          if (word_done) begin
            if (section == SEC_BODY && word_idx == LAST_IDX) begin
              state     <= IDLE;
              busy      <= 1'b0;
              section   <= SEC_PC;
              word_idx  <= '0;
              du_areg   <= 5'd0;
              du_rd_reg <= 1'b0;
              du_amem   <= 32'h0;
              du_rd_mem <= 1'b0;
            end else begin
              state <= DUMP_ADDR;
              case (section)
                SEC_PC: begin
`ifdef DEBUG_CYCLE_COUNT_EN
                  section <= SEC_CNT;
`else
                  section <= SEC_BODY;
`endif
                end
                SEC_CNT: section  <= SEC_BODY;
                default: word_idx <= word_idx + IDX_W'(1);
              endcase
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_debug_unit.sv
// tb_mips_debug_unit: scoreboard bench for mips_debug_unit. Expected frame
// bytes are queued when a command is sent and popped as the DUT hands each
// byte to the transmitter. The bench acts as the core: register reads
// return a hash of the index, memory reads a hash of the byte address.
module tb_mips_debug_unit;
  import du_pkg::*;

  localparam int MEM_WORDS = 32;
  localparam int ADDR_STEP = 4;
`ifdef DEBUG_CYCLE_COUNT_EN
  localparam bit WITH_CNT = 1'b1;
`else
  localparam bit WITH_CNT = 1'b0;
`endif
  localparam int FRAME_BYTES = frame_words(MEM_WORDS, WITH_CNT) * BYTES_PER_WORD;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        mips_ena;
  logic        mips_halted;
  logic [31:0] mips_pc;
  logic [4:0]  du_areg;
  logic        du_rd_reg;
  logic [31:0] du_amem;
  logic        du_rd_mem;
  logic [31:0] reg_data;
  logic [31:0] mem_data;
  logic        busy;

  mips_debug_unit #(
    .MEM_DUMP_WORDS (MEM_WORDS),
    .MEM_ADDR_STEP  (ADDR_STEP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .mips_ena    (mips_ena),
    .mips_halted (mips_halted),
    .mips_pc     (mips_pc),
    .du_areg     (du_areg),
    .du_rd_reg   (du_rd_reg),
    .du_amem     (du_amem),
    .du_rd_mem   (du_rd_mem),
    .reg_data    (reg_data),
    .mem_data    (mem_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [7:0]  exp_q[$];
  bit          pattern;
  int          model_cnt;
  int          got_bytes;
  int          ena_cycles;
  int          unstable;
  int          busy_early_low;
  bit          timed_out;

  function automatic logic [31:0] reg_model(input logic [4:0] a, input bit p);
    return p ? (32'h9E3779B9 * (32'(a) + 32'd1)) : 32'(a);
  endfunction

  function automatic logic [31:0] mem_model(input logic [31:0] addr, input bit p);
    return p ? ((addr * 32'h01000193) ^ 32'hDEADBEEF) : addr;
  endfunction

  // Without the matching select the core would return unrelated data.
  assign reg_data = du_rd_reg ? reg_model(du_areg, pattern) : 32'h0BAD_F00D;
  assign mem_data = du_rd_mem ? mem_model(du_amem, pattern) : 32'h0BAD_F00D;

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
  endtask

  task automatic push_frame();
    push_word(mips_pc);
    if (WITH_CNT) push_word(32'(model_cnt));
    for (int i = 0; i < REG_COUNT; i++) push_word(reg_model(5'(i), pattern));
    for (int i = 0; i < MEM_WORDS; i++) push_word(mem_model(32'(i * ADDR_STEP), pattern));
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Runs from the negedge after a command edge; drives tx_ready/halt/inject
  // for the next posedge and scores every byte that will be accepted there.
  task automatic collect(input int ready_mode, input int halt_edge,
                         input int inject_at, input int stop_at);
    int          k;
    bit          injected;
    logic        prev_valid;
    logic [4:0]  prev_areg;
    logic        prev_rd_reg;
    logic        prev_rd_mem;
    logic [31:0] prev_amem;
    logic [7:0]  exp_b;
    got_bytes = 0; ena_cycles = 0; unstable = 0; busy_early_low = 0;
    timed_out = 1'b0; injected = 1'b0; prev_valid = 1'b0;
    prev_areg = 5'd0; prev_rd_reg = 1'b0; prev_rd_mem = 1'b0; prev_amem = 32'h0;
    k = 0;
    forever begin
      if (k >= 6000) begin
        timed_out = 1'b1;
        break;
      end
      if (ready_mode == 0) tx_ready = 1'b1;
      else if (ready_mode == 1) tx_ready = ((k % 3) == 0);
      else tx_ready = 1'($urandom_range(0, 1));
      if (halt_edge > 0 && k + 1 == halt_edge) mips_halted = 1'b1;
      if (rx_valid) begin
        rx_valid = 1'b0;
        rx_data  = 8'h00;
      end
      if (inject_at >= 0 && !injected && got_bytes == inject_at) begin
        rx_valid = 1'b1;
        rx_data  = CMD_STEP;
        injected = 1'b1;
      end
      ena_cycles += int'(mips_ena);
      if (tx_valid && prev_valid &&
          (du_areg !== prev_areg || du_rd_reg !== prev_rd_reg ||
           du_amem !== prev_amem || du_rd_mem !== prev_rd_mem))
        unstable++;
      prev_valid = tx_valid; prev_areg = du_areg; prev_rd_reg = du_rd_reg;
      prev_amem = du_amem; prev_rd_mem = du_rd_mem;
      if (tx_valid && tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL frame_byte[%0d]: got %02h, expected no further byte", got_bytes, tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx_data !== exp_b) begin
            errors++;
            $display("[TB] FAIL frame_byte[%0d]: got %02h, expected %02h", got_bytes, tx_data, exp_b);
          end
        end
        got_bytes++;
      end
      if (k > 0 && busy === 1'b0) begin
        if (exp_q.size() != 0) busy_early_low++;
        break;
      end
      if (stop_at >= 0 && got_bytes >= stop_at) break;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    mips_halted = 1'b0; mips_pc = 32'h0; pattern = 1'b0; model_cnt = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_valid, tx_data, mips_ena, du_areg, du_rd_reg, du_amem, du_rd_mem, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b data=%02h ena=%b areg=%0d rdreg=%b amem=%08h rdmem=%b busy=%b, expected all 0",
               tx_valid, tx_data, mips_ena, du_areg, du_rd_reg, du_amem, du_rd_mem, busy);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_valid, mips_ena, du_rd_reg, du_rd_mem, busy} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got valid=%b ena=%b rdreg=%b rdmem=%b busy=%b, expected all 0",
               tx_valid, mips_ena, du_rd_reg, du_rd_mem, busy);
    end
  endtask

  task automatic test_ignore();
    send_cmd(8'h41);
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, mips_ena, tx_valid} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL unknown_cmd: got busy=%b ena=%b valid=%b, expected 000", busy, mips_ena, tx_valid);
    end
  endtask

  task automatic test_dump();
    pattern = 1'b0;
    mips_pc = 32'h0000_0010;
    push_frame();
    send_cmd(CMD_DUMP);
    collect(0, 0, -1, -1);
    checks++;
    if (timed_out || got_bytes != FRAME_BYTES) begin
      errors++;
      $display("[TB] FAIL dump_length: got %0d bytes (timeout=%b), expected %0d", got_bytes, timed_out, FRAME_BYTES);
    end
    checks++;
    if (ena_cycles != 0) begin
      errors++;
      $display("[TB] FAIL dump_ena: got %0d enabled cycles, expected 0", ena_cycles);
    end
    checks++;
    if ({tx_valid, mips_ena, du_areg, du_rd_reg, du_amem, du_rd_mem, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL dump_end_idle: got areg=%0d rdreg=%b amem=%08h rdmem=%b busy=%b, expected all 0",
               du_areg, du_rd_reg, du_amem, du_rd_mem, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_run();
    pattern = 1'b1;
    mips_pc = 32'h1234_5678;
    model_cnt += 20;
    push_frame();
    send_cmd(CMD_RUN);
    collect(0, 20, -1, -1);
    mips_halted = 1'b0;
    checks++;
    if (ena_cycles != 20) begin
      errors++;
      $display("[TB] FAIL run_ena_cycles: got %0d, expected 20", ena_cycles);
    end
    checks++;
    if (timed_out || got_bytes != FRAME_BYTES || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL run_length: got %0d bytes (timeout=%b), expected %0d", got_bytes, timed_out, FRAME_BYTES);
    end
    exp_q.delete();
  endtask

  task automatic test_step();
    pattern = 1'b1;
    mips_pc = 32'hCAFE_F00D;
    mips_halted = 1'b0;
    model_cnt += 1;
    push_frame();
    send_cmd(CMD_STEP);
    collect(0, 0, -1, -1);
    checks++;
    if (ena_cycles != 1) begin
      errors++;
      $display("[TB] FAIL step_ena_cycles: got %0d, expected 1", ena_cycles);
    end
    checks++;
    if (timed_out || got_bytes != FRAME_BYTES || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL step_length: got %0d bytes (timeout=%b), expected %0d", got_bytes, timed_out, FRAME_BYTES);
    end
    exp_q.delete();
  endtask

  task automatic test_halted_cmds();
    pattern = 1'b0;
    mips_pc = 32'h0040_0000;
    mips_halted = 1'b1;
    push_frame();
    send_cmd(CMD_STEP);
    collect(0, 0, -1, -1);
    checks++;
    if (ena_cycles != 0 || got_bytes != FRAME_BYTES) begin
      errors++;
      $display("[TB] FAIL halted_step: got ena_cycles=%0d bytes=%0d, expected 0 and %0d", ena_cycles, got_bytes, FRAME_BYTES);
    end
    exp_q.delete();
    push_frame();
    send_cmd(CMD_RUN);
    collect(0, 0, -1, -1);
    checks++;
    if (ena_cycles != 0 || got_bytes != FRAME_BYTES) begin
      errors++;
      $display("[TB] FAIL halted_run: got ena_cycles=%0d bytes=%0d, expected 0 and %0d", ena_cycles, got_bytes, FRAME_BYTES);
    end
    mips_halted = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    pattern = 1'b1;
    mips_pc = 32'hA5A5_5A5A;
    push_frame();
    send_cmd(CMD_DUMP);
    collect(1, 0, -1, -1);
    checks++;
    if (timed_out || got_bytes != FRAME_BYTES || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL backpressure_length: got %0d bytes (timeout=%b), expected %0d", got_bytes, timed_out, FRAME_BYTES);
    end
    checks++;
    if (unstable != 0) begin
      errors++;
      $display("[TB] FAIL addr_stable: got %0d address changes within a word, expected 0", unstable);
    end
    exp_q.delete();
  endtask

  task automatic test_mid_dump_cmd();
    pattern = 1'b0;
    mips_pc = 32'h0000_0077;
    push_frame();
    send_cmd(CMD_DUMP);
    collect(2, 0, 50, -1);
    checks++;
    if (busy_early_low != 0 || ena_cycles != 0) begin
      errors++;
      $display("[TB] FAIL mid_dump_cmd: got early_idle=%0d ena_cycles=%0d, expected 0 and 0", busy_early_low, ena_cycles);
    end
    checks++;
    if (timed_out || got_bytes != FRAME_BYTES || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL mid_dump_length: got %0d bytes (timeout=%b), expected %0d", got_bytes, timed_out, FRAME_BYTES);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    pattern = 1'b1;
    mips_pc = 32'h0BAD_BEEF;
    push_frame();
    send_cmd(CMD_DUMP);
    collect(0, 0, -1, 100);
    checks++;
    if (timed_out || got_bytes != 100) begin
      errors++;
      $display("[TB] FAIL reset_mid_reach: got %0d bytes (timeout=%b), expected 100", got_bytes, timed_out);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({tx_valid, tx_data, mips_ena, du_areg, du_rd_reg, du_amem, du_rd_mem, busy} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got valid=%b data=%02h ena=%b areg=%0d rdreg=%b amem=%08h rdmem=%b busy=%b, expected all 0",
               tx_valid, tx_data, mips_ena, du_areg, du_rd_reg, du_amem, du_rd_mem, busy);
    end
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    push_frame();
    send_cmd(CMD_DUMP);
    collect(0, 0, -1, -1);
    checks++;
    if (timed_out || got_bytes != FRAME_BYTES || exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL after_reset_length: got %0d bytes (timeout=%b), expected %0d", got_bytes, timed_out, FRAME_BYTES);
    end
    exp_q.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ignore();
    test_dump();
    test_run();
    test_step();
    test_halted_cmds();
    test_backpressure();
    test_mid_dump_cmd();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/mips_debug_unit.md
# mips_debug_unit

Command-driven debug controller sitting directly upstream of the pipelined MIPS core. It accepts byte commands from a UART receiver and gates the core clock enable for continuous run or single step. It then walks the core's register file and data memory through the debug address ports and streams a dump frame, MSB first, to a UART transmitter.

## Interface
- MEM_DUMP_WORDS, 32: number of data-memory words in each dump.
- MEM_ADDR_STEP, 4: byte increment of `du_amem` between dumped words.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- rx_valid  in  1  one-cycle strobe; `rx_data` holds a received byte.
- rx_data  in  8  received command byte.
- tx_valid  out  1  byte available on `tx_data`.
- tx_data  out  8  byte to transmit.
- tx_ready  in  1  transmitter accepts byte this cycle.
- mips_ena  out  1  core clock enable (to `mdb_ena`).
- mips_halted  in  1  core halt flag (from `PC_endM`).
- mips_pc  in  32  current core PC.
- du_areg  out  5  register-file debug read address.
- du_rd_reg  out  1  selects debug register address in core.
- du_amem  out  32  data-memory debug byte address.
- du_rd_mem  out  1  selects debug memory address/read in core.
- reg_data  in  32  register read data for `du_areg`.
- mem_data  in  32  memory read data for `du_amem`.
- busy  out  1  high in any state other than IDLE.

## Operation
- Commands are accepted only in IDLE; `rx_valid` in any other state is dropped.
  - 0x63 'c': run.
  - 0x73 's': step.
  - 0x64 'd': dump.
  - Any other byte is ignored.
- States: IDLE, RUN, STEP, DUMP_ADDR, DUMP_SETTLE, DUMP_LATCH, TX_BYTE.
- RUN:
  - `mips_ena`=1 until `mips_halted` is sampled high, then go to DUMP_ADDR.
  - If `mips_halted` is already 1 on entry, `mips_ena` is never asserted and the FSM goes straight to the dump.
- STEP:
  - `mips_ena`=1 for exactly one cycle, then DUMP_ADDR.
  - If the core is halted, the enable is suppressed and only the dump runs.
- Dump frame order:
  - PC.
  - Cycle count, only with the macro below.
  - Registers 0..31.
  - Memory words at addresses 0, STEP, 2·STEP, up to (MEM_DUMP_WORDS−1)·STEP.
  - Each word is sent as 4 bytes, [31:24] first.
- Per word:
  - DUMP_ADDR drives the address and select. For register words: `du_rd_reg`=1, `du_areg`=index. For memory words: `du_rd_mem`=1, `du_amem`=index·MEM_ADDR_STEP.
  - DUMP_SETTLE holds the address for one cycle.
  - DUMP_LATCH captures `reg_data`, `mem_data` or `mips_pc` into a 32-bit shift register.
  - TX_BYTE sends 4 bytes.
- Address and select outputs hold stable from DUMP_ADDR until DUMP_LATCH completes.
- After the last byte of the last word, return to IDLE with all debug outputs deasserted.
- Outside a dump: `du_rd_reg`=0, `du_rd_mem`=0, `du_areg`=0, `du_amem`=0.
- `mips_ena` is 0 in every state other than RUN and STEP.

## Timing
- Reset values: every output 0. FSM in IDLE, word index 0, shift register 0.
- All outputs are registered.
- `mips_ena` rises on the edge after the `rx_valid` cycle and falls on the edge after `mips_halted` is sampled high.
- TX handshake: `tx_valid`/`tx_data` hold until a cycle with `tx_valid`&`tx_ready`. The next byte is presented on the following edge; there is no gap requirement.
- Per-word latency is 3 cycles plus 4 accepted handshakes.
- Full frame is 1+32+MEM_DUMP_WORDS words; 65 words / 260 bytes at defaults.
- Reset mid-operation: immediate return to IDLE with `mips_ena`=0, `tx_valid`=0, and any partial frame abandoned.
- Word index is 6 bits and wide enough for 32 + MEM_DUMP_WORDS. It never wraps within a frame.

## Configuration
- `DEBUG_CYCLE_COUNT_EN` defined:
  - A 32-bit counter increments on every cycle with `mips_ena`=1. It is cleared only by reset and wraps modulo 2^32.
  - Its value is sent as the second frame word, latched in DUMP_LATCH.
  - Frame grows by 4 bytes.
- Undefined: no counter, and the frame starts PC then registers.

## Structure
- Package `du_pkg` holds:
  - Command byte constants.
  - State enum.
  - REG_COUNT=32.
  - Bytes-per-word=4.
  - Frame-word count function.
- Sub-module `du_word_serializer`:
  - Inputs: 32-bit load with load strobe.
  - Output: 4-byte valid/ready stream, MSB first.
  - Provides a done pulse after the 4th accepted byte.

## Test plan
- Reset then 'd' with `mips_pc`=0x0000_0010, `reg_data`=index, `mem_data`=addr, `tx_ready`=1:
  - Frame is 00 00 00 10, then 00 00 00 00 … 00 00 00 1F, then memory 00 00 00 00 … 00 00 00 7C.
  - 260 bytes total, `mips_ena` never high.
- 's' with `mips_halted`=0 → `mips_ena` high for exactly 1 cycle, then the full dump.
- 'c' with `mips_halted` raised 20 cycles later → `mips_ena` high for 20 cycles, deasserts the cycle after halt is sampled, then the dump. With the macro, the cycle-count word reads 0x0000_0014.
- `tx_ready` toggled 1-of-3 cycles during the dump → no byte lost or duplicated, and `du_areg` stable across each word's bytes.
- Extra 's' on `rx_valid` mid-dump → ignored; the frame is unchanged and `busy` stays 1.
- `reset` asserted at byte 100 of the dump → outputs 0 at once; a following 'd' yields a complete 260-byte frame.
